// File: rtl/word_splitter.sv
// word_splitter
//   Splits each accepted 16-bit word {hi, lo} into two bytes on a
//   valid/ready byte stream. The first byte goes out in the cycle after the
//   word is accepted. The second byte's handshake can accept the next word
//   on the same edge, so a continuous stream runs at one word per two cycles.
//
// Parameters
//   MSB_FIRST  : 1 = hi byte first, 0 = lo byte first
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous, active-high reset
//   in_word    : word to split, {hi[15:8], lo[7:0]}
//   in_valid   : in_word is valid
//   in_ready   : the block accepts in_word this cycle
//   out_byte   : current output byte (8'h00 while out_valid = 0)
//   out_valid  : out_byte is valid
//   out_ready  : downstream accepts out_byte this cycle
//   out_last   : out_byte is the second byte of its word
//   out_rep    : the current word had hi == lo
//   word_count : number of fully emitted words, modulo 256
module word_splitter #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_rep,
  output logic [7:0]  word_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_1 = 2'd1,
    SEND_2 = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] hold_reg;
  logic        rep_reg;
  logic [7:0]  count_reg;

  logic [7:0]  first_byte;
  logic [7:0]  second_byte;

  assign first_byte  = MSB_FIRST ? hold_reg[15:8] : hold_reg[7:0];
  assign second_byte = MSB_FIRST ? hold_reg[7:0]  : hold_reg[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      hold_reg  <= 16'h0000;
      rep_reg   <= 1'b0;
      count_reg <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            hold_reg  <= in_word;
            rep_reg   <= (in_word[15:8] == in_word[7:0]);
            state_reg <= SEND_1;
          end
        end
        SEND_1: begin
          if (out_ready) begin
            state_reg <= SEND_2;
          end
        end
        SEND_2: begin
          if (out_ready) begin
            count_reg <= count_reg + 8'd1;
            // Accepting the next word on the last byte's handshake avoids
            // a bubble between consecutive words.
            if (in_valid) begin
              hold_reg  <= in_word;
              rep_reg   <= (in_word[15:8] == in_word[7:0]);
              state_reg <= SEND_1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Output decode from the state register. rst masks every handshake output
  // in the same cycle, so nothing appears valid or ready while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_rep   = 1'b0;
    out_byte  = 8'h00;
    if (!rst) begin
      case (state_reg)
        IDLE: begin
          in_ready = 1'b1;
        end
        SEND_1: begin
          out_valid = 1'b1;
          out_byte  = first_byte;
          out_rep   = rep_reg;
        end
        SEND_2: begin
          out_valid = 1'b1;
          out_last  = 1'b1;
          out_byte  = second_byte;
          out_rep   = rep_reg;
          in_ready  = out_ready;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  assign word_count = count_reg;

endmodule

// File: doc/word_splitter.md
WORD_SPLITTER -- requirements
Module: word_splitter

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1: 1 emits the upper byte first, 0 emits the lower byte first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_word, input, 16 bits: the word to split, {hi[15:8], lo[7:0]}.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_word is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_word this cycle.
REQ-007 The block SHALL have port out_byte, output, 8 bits: the current output byte.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_byte is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream accepts out_byte this cycle.
REQ-010 The block SHALL have port out_last, output, 1 bit: out_byte is the second byte of its word.
REQ-011 The block SHALL have port out_rep, output, 1 bit: the current word had hi == lo (replicated byte).
REQ-012 The block SHALL have port word_count, output, 8 bits: count of fully emitted words, modulo 256.

Function
REQ-013 Handshakes SHALL complete only on a rising edge where valid and ready are both 1; in_word SHALL be sampled only at an input handshake.
REQ-014 The FSM SHALL have three states: IDLE, SEND_1 (first byte) and SEND_2 (second byte).
REQ-015 In IDLE: out_valid=0, out_last=0, in_ready=1; an input handshake SHALL load the hold register and the rep flag (hi==lo), then go to SEND_1.
REQ-016 In SEND_1: out_valid=1, out_last=0, in_ready=0, out_byte=hi if MSB_FIRST=1 else lo; out_ready=1 SHALL go to SEND_2; otherwise the state SHALL hold.
REQ-017 In SEND_2: out_valid=1, out_last=1, out_byte = the other byte of the word, and in_ready SHALL equal out_ready (combinational).
REQ-018 SEND_2 with out_ready=1 and in_valid=1: the block SHALL complete the output handshake and load the new word in the same edge, then go to SEND_1 with no bubble cycle.
REQ-019 SEND_2 with out_ready=1 and in_valid=0: the block SHALL go to IDLE.
REQ-020 SEND_2 with out_ready=0: the state SHALL hold and no input SHALL be accepted.
REQ-021 Latency SHALL be one cycle: a word accepted at edge N drives its first byte with out_valid=1 in the cycle after edge N.
REQ-022 Sustained throughput SHALL be one word per 2 cycles when out_ready=1 and in_valid=1 continuously.
REQ-023 out_byte, out_rep and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 out_rep SHALL be set from the captured word and held constant across both bytes of that word.
REQ-025 word_count SHALL increment by 1 on each SEND_2 output handshake and SHALL wrap from 255 to 0.
REQ-026 While out_valid=0, out_byte SHALL be 8'h00.

Reset
REQ-027 While rst=1 at a rising edge: state=IDLE, hold register=16'h0000, rep flag=0, word_count=0.
REQ-028 While rst=1: in_ready=0, out_valid=0, out_last=0, out_rep=0, out_byte=8'h00, regardless of other inputs.
REQ-029 A reset asserted mid-word SHALL discard the remaining byte; that word SHALL not be counted.
REQ-030 The first cycle after rst falls SHALL be IDLE with in_ready=1.

Verification
REQ-031 MSB_FIRST=1, in_word=16'hFA0F, out_ready=1 -> out_byte FA (last=0), then 0F (last=1); out_rep=0; word_count=1.
REQ-032 MSB_FIRST=0, in_word=16'hFA0F -> 0F then FA; in_word=16'hFAFA -> out_rep=1 on both bytes.
REQ-033 Back-to-back 16'h1234, 16'h5678 with in_valid=1 and out_ready=1 -> bytes 12,34,56,78 on 4 consecutive cycles; in_ready=1 only on the cycles that output 34 and 78.
REQ-034 16'hABCD with out_ready held at 0 for 3 cycles in SEND_1 -> AB held stable for 3 cycles with in_ready=0; then CD follows.
REQ-035 rst=1 in SEND_2 of 16'h0F0F -> next cycle out_valid=0 and word_count=0; after rst falls, 16'h0102 emits 01,02.
REQ-036 Emit 256 words -> word_count wraps to 0; 257 words -> word_count=1.
